// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_pkg;

  typedef enum logic {ARB, XFER} wrArbState_t;

  localparam int MAX_REQ = 32;

  // Reference round-robin index: first set bit strictly after lastId, with wrap.
  function automatic int rr_next(input logic [MAX_REQ-1:0] valid, input int lastId, input int nReq);
    int k;
    for (int s = 1; s <= nReq; s++) begin
      k = (lastId + s) % nReq;
      if (valid[k]) return k;
    end
    return lastId;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin picker: first valid index strictly after lastId.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [ID_W-1:0]  lastId,
  output logic             anyValid,
  output logic [ID_W-1:0]  pickId
);

  logic [N_REQ-1:0] rot;
  int               offset;
  int               sum;

  always_comb begin
    // Rotating the doubled vector puts index lastId+1 at bit 0, so wrap comes for free.
    rot    = N_REQ'({valid, valid} >> (int'(lastId) + 1));
    offset = 0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offset = i;
    end
    sum = int'(lastId) + 1 + offset;
    if (sum >= N_REQ) sum = sum - N_REQ;
    pickId   = ID_W'(sum);
    anyValid = |valid;
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-based round-robin arbiter sharing one FIFO write port between N_REQ producers.
module fifo_wr_arb
  import fifo_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 8,
  parameter int ID_W      = $clog2(N_REQ),
  parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
  input  logic                    i_clk,
  input  logic                    i_arst,
  input  logic [N_REQ-1:0]        i_valid,
  input  logic [N_REQ-1:0]        i_last,
  input  logic [N_REQ*DATA_W-1:0] i_data,
  output logic [N_REQ-1:0]        o_ready,
  input  logic                    i_wFull,
  output logic                    o_wInc,
  output logic [DATA_W-1:0]       o_wData,
  output logic [ID_W-1:0]         o_grantId,
  output logic                    o_busy
);

  wrArbState_t      state, stateNxt;
  logic [ID_W-1:0]  grantId, lastId, pickId;
  logic [CNT_W-1:0] burstCnt;
  logic             anyValid, xfer, relGrant;

  rr_pick #(.N_REQ(N_REQ), .ID_W(ID_W)) uPick (
    .valid    (i_valid),
    .lastId   (lastId),
    .anyValid (anyValid),
    .pickId   (pickId)
  );

  assign xfer     = (state == XFER) & i_valid[grantId] & ~i_wFull;
  // A word carrying last on the burst-limit beat still yields exactly one release.
  assign relGrant = xfer & (i_last[grantId] | (burstCnt == CNT_W'(MAX_BURST - 1)));

  always_comb begin
    stateNxt  = state;
    o_ready   = '0;
    o_wInc    = xfer;
    o_wData   = i_data[grantId*DATA_W +: DATA_W];
    o_grantId = grantId;
    o_busy    = 1'b0;
    case (state)
      ARB: begin
        if (anyValid) stateNxt = XFER;
      end
      XFER: begin
        o_busy = 1'b1;
        if (!i_wFull) o_ready = N_REQ'(1) << grantId;
        if (relGrant) stateNxt = ARB;
      end
      default: stateNxt = ARB;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_arst) begin
    if (!i_arst) begin
      state    <= ARB;
      grantId  <= '0;
      lastId   <= ID_W'(N_REQ - 1);
      burstCnt <= '0;
    end else begin
      state <= stateNxt;
      if (state == ARB && anyValid) begin
        grantId  <= pickId;
        burstCnt <= '0;
      end
      if (relGrant) lastId <= grantId;
      else if (xfer) burstCnt <= burstCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: vector table, directed corner sequences, random traffic.
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 8;

  logic          clk = 1'b0;
  logic          arst;
  logic [N-1:0]  valid, last;
  logic [N*DW-1:0] data;
  logic          wFull;
  logic [N-1:0]  ready;
  logic          wInc;
  logic [DW-1:0] wData;
  logic [1:0]    gid;
  logic          busy;

  fifo_wr_arb #(.N_REQ(N), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .i_clk     (clk),
    .i_arst    (arst),
    .i_valid   (valid),
    .i_last    (last),
    .i_data    (data),
    .o_ready   (ready),
    .i_wFull   (wFull),
    .o_wInc    (wInc),
    .o_wData   (wData),
    .o_grantId (gid),
    .o_busy    (busy)
  );

  always #5 clk = ~clk;

  int nCmp = 0;
  int nFail = 0;
  int cyc = 0;

  // Reference model state: who owns the port, words taken in this grant, previous owner.
  bit mXfer;
  int mGrant, mLast, mCnt;

  logic [N-1:0]  obsReady, accepted;
  logic          obsInc, obsBusy;
  logic [DW-1:0] obsData;
  logic [1:0]    obsGid;

  bit sbOn = 0;
  logic [DW-1:0] sbQ [N][$];

  typedef struct packed {
    logic [3:0] v;
    logic [3:0] l;
    logic       f;
    logic [7:0] d1;
    logic [7:0] d3;
    logic [3:0] eRdy;
    logic       eInc;
    logic [7:0] eData;
    logic [1:0] eGid;
    logic       eBusy;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nCmp++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, got, exp);
    end
  endtask

  task automatic modelReset();
    mXfer  = 0;
    mGrant = 0;
    mLast  = N - 1;
    mCnt   = 0;
  endtask

  function automatic int firstAfter(input logic [N-1:0] v, input int prev);
    for (int s = 1; s <= N; s++) begin
      if (v[(prev + s) % N]) return (prev + s) % N;
    end
    return -1;
  endfunction

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    logic [N-1:0]  eRdy;
    logic          eInc;
    logic [DW-1:0] eData;
    logic [DW-1:0] sbExp;
    int            p;
    @(negedge clk);
    if (!arst) modelReset();
    eRdy  = (mXfer && !wFull) ? 4'(1 << mGrant) : 4'b0;
    eInc  = mXfer && valid[mGrant] && !wFull;
    eData = data[mGrant*DW +: DW];
    chk("ready", ready, eRdy);
    chk("wInc", wInc, eInc);
    chk("wData", wData, eData);
    chk("grantId", gid, mGrant);
    chk("busy", busy, mXfer);
    obsReady = ready;
    obsInc   = wInc;
    obsData  = wData;
    obsGid   = gid;
    obsBusy  = busy;
    accepted = valid & ready;
    if (sbOn && wInc) begin
      if (sbQ[gid].size() == 0) begin
        nCmp++;
        nFail++;
        $display("FAIL sbEmpty cyc=%0d got=%0h exp=none from producer %0d", cyc, wData, gid);
      end else begin
        sbExp = sbQ[gid].pop_front();
        chk("sbData", wData, sbExp);
      end
    end
    if (arst) begin
      if (!mXfer) begin
        p = firstAfter(valid, mLast);
        if (p >= 0) begin
          mGrant = p;
          mCnt   = 0;
          mXfer  = 1;
        end
      end else if (eInc) begin
        if (last[mGrant] || mCnt == MB - 1) begin
          mLast = mGrant;
          mXfer = 0;
        end else begin
          mCnt++;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic doReset();
    valid = 4'hF;
    last  = '0;
    wFull = 1'b0;
    arst  = 1'b0;
    cycle();
    chk("rstInc", obsInc, 0);
    chk("rstReady", obsReady, 0);
    chk("rstBusy", obsBusy, 0);
    chk("rstGid", obsGid, 0);
    cycle();
    arst  = 1'b1;
    valid = '0;
    for (int k = 0; k < N; k++) sbQ[k].delete();
  endtask

  initial begin
    logic [7:0] wr[$];
    int gIds[5];
    int pulses[5];
    int nG, stall, sent0, rel;
    bit prevBusy, resumed, chkResume;

    modelReset();
    arst  = 1'b0;
    valid = '0;
    last  = '0;
    data  = '0;
    wFull = 1'b0;

    // Single producer, then lastId check via a 1/3 contention, with one full cycle.
    tbl[0] = '{4'b0010, 4'b0000, 1'b0, 8'hA1, 8'h00, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1] = '{4'b0010, 4'b0000, 1'b0, 8'hA1, 8'h00, 4'b0010, 1'b1, 8'hA1, 2'd1, 1'b1};
    tbl[2] = '{4'b0010, 4'b0000, 1'b0, 8'hA2, 8'h00, 4'b0010, 1'b1, 8'hA2, 2'd1, 1'b1};
    tbl[3] = '{4'b0010, 4'b0010, 1'b0, 8'hA3, 8'h00, 4'b0010, 1'b1, 8'hA3, 2'd1, 1'b1};
    tbl[4] = '{4'b0000, 4'b0000, 1'b0, 8'hA3, 8'h00, 4'b0000, 1'b0, 8'hA3, 2'd1, 1'b0};
    tbl[5] = '{4'b1010, 4'b0000, 1'b0, 8'hA3, 8'hB1, 4'b0000, 1'b0, 8'hA3, 2'd1, 1'b0};
    tbl[6] = '{4'b1010, 4'b1000, 1'b1, 8'hA3, 8'hB1, 4'b0000, 1'b0, 8'hB1, 2'd3, 1'b1};
    tbl[7] = '{4'b1010, 4'b1000, 1'b0, 8'hA3, 8'hB1, 4'b1000, 1'b1, 8'hB1, 2'd3, 1'b1};
    tbl[8] = '{4'b0000, 4'b0000, 1'b0, 8'hA3, 8'hB1, 4'b0000, 1'b0, 8'hB1, 2'd3, 1'b0};

    doReset();
    for (int i = 0; i < 9; i++) begin
      valid = tbl[i].v;
      last  = tbl[i].l;
      wFull = tbl[i].f;
      data  = {tbl[i].d3, 8'h00, tbl[i].d1, 8'h00};
      cycle();
      chk("tblReady", obsReady, tbl[i].eRdy);
      chk("tblInc", obsInc, tbl[i].eInc);
      chk("tblData", obsData, tbl[i].eData);
      chk("tblGid", obsGid, tbl[i].eGid);
      chk("tblBusy", obsBusy, tbl[i].eBusy);
    end

    // All valid, endless packets: rotation 0,1,2,3,0 with 8 writes per grant.
    doReset();
    valid = 4'hF;
    data  = 32'h44332211;
    nG = 0;
    prevBusy = 0;
    for (int i = 0; i < 46; i++) begin
      cycle();
      if (obsBusy && !prevBusy && nG < 5) begin
        gIds[nG]   = obsGid;
        pulses[nG] = 0;
        nG++;
      end
      if (obsInc && nG > 0) pulses[nG-1]++;
      prevBusy = obsBusy;
    end
    chk("rotGrants", nG, 5);
    for (int i = 0; i < nG; i++) begin
      chk("rotOrder", gIds[i], i % N);
      chk("rotBurst", pulses[i], MB);
    end

    // Full stall after req2's third word for 5 cycles.
    doReset();
    valid = 4'b0100;
    data  = 32'h00210000;
    stall = 0;
    resumed = 0;
    wr.delete();
    for (int c = 0; c < 14; c++) begin
      wFull = (wr.size() == 3 && stall < 5);
      if (wFull) stall++;
      chkResume = (stall == 5 && !wFull && !resumed);
      cycle();
      if (obsInc) wr.push_back(obsData);
      if (accepted[2]) data[23:16] = data[23:16] + 8'd1;
      if (wFull) begin
        chk("stallInc", obsInc, 0);
        chk("stallReady", obsReady, 0);
        chk("stallCnt", dut.burstCnt, 3);
      end
      if (chkResume) begin
        resumed = 1;
        chk("resumeInc", obsInc, 1);
        chk("resumeData", obsData, 8'h24);
      end
    end
    valid = '0;
    cycle();
    chk("stallWords", wr.size(), 8);
    for (int i = 0; i < wr.size() && i < 8; i++) chk("stallSeq", wr[i], 8'h21 + i);

    // Last on the burst-limit word: one release, then req1.
    doReset();
    valid = 4'b0011;
    data  = 32'h00005101;
    sent0 = 0;
    rel = 0;
    prevBusy = 0;
    for (int c = 0; c < 12; c++) begin
      last[0] = valid[0] && (sent0 == MB - 1);
      cycle();
      if (prevBusy && !obsBusy) rel++;
      prevBusy = obsBusy;
      if (accepted[0]) begin
        sent0++;
        data[7:0] = data[7:0] + 8'd1;
        if (sent0 == MB) begin
          valid[0] = 1'b0;
          last[0]  = 1'b0;
        end
      end
    end
    chk("bndWords", sent0, MB);
    chk("bndReleases", rel, 1);
    chk("bndNextGid", obsGid, 1);

    // Reset in the middle of req3's burst.
    doReset();
    valid = 4'b1000;
    data  = 32'h31000000;
    for (int c = 0; c < 3; c++) begin
      cycle();
      if (accepted[3]) data[31:24] = data[31:24] + 8'd1;
    end
    #1;
    chk("preRstInc", wInc, 1);
    arst = 1'b0;
    #1;
    chk("asyncInc", wInc, 0);
    chk("asyncBusy", busy, 0);
    chk("asyncReady", ready, 0);
    chk("asyncGid", gid, 0);
    modelReset();
    cycle();
    arst  = 1'b1;
    valid = 4'hF;
    cycle();
    cycle();
    chk("postRstGid", obsGid, 0);

    // Random traffic with in-order per-producer scoreboard.
    doReset();
    last = '0;
    sbOn = 1;
    for (int c = 0; c < 3000; c++) begin
      wFull = ($urandom_range(0, 5) == 0);
      cycle();
      for (int k = 0; k < N; k++) begin
        if (accepted[k] || !valid[k]) begin
          if ($urandom_range(0, 3) != 0) begin
            valid[k] = 1'b1;
            data[k*DW +: DW] = 8'($urandom);
            last[k] = ($urandom_range(0, 4) == 0);
            sbQ[k].push_back(data[k*DW +: DW]);
          end else begin
            valid[k] = 1'b0;
            last[k]  = 1'b0;
          end
        end
      end
    end
    for (int k = 0; k < N; k++) chk("sbPending", sbQ[k].size(), valid[k] ? 1 : 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
